// File: rtl/fetch_decode_queue_pkg.sv
// Shared types for the fetch/decode queue: the decode request slot, the
// stored queue entry and a helper that marks which entry bits a given
// WIDTH actually uses.
package fetch_decode_queue_pkg;

  localparam int WIDTH_MAX = 8;

  // One decode slot as handed from IF to ID
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } DECODE_REQUIRE;

  // One queue entry, sized for the widest supported bundle
  typedef struct packed {
    logic [WIDTH_MAX-1:0]          mask;
    DECODE_REQUIRE [WIDTH_MAX-1:0] bundle;
  } fdq_entry_t;

  localparam fdq_entry_t FDQ_ZERO_ENTRY = '0;

  // Ones in every bit that belongs to one of the low `width` slots
  function automatic fdq_entry_t fdq_keep_mask(int width);
    fdq_entry_t m;
    m = FDQ_ZERO_ENTRY;
    for (int i = 0; i < WIDTH_MAX; i++) begin
      if (i < width) begin
        m.mask[i]   = 1'b1;
        m.bundle[i] = '1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/fdq_ring_ptr.sv
// DEPTH-modulo ring pointer used for both the head and the tail of the
// fetch/decode queue. Wraps explicitly at DEPTH-1 so DEPTH need not be a
// power of two.
module fdq_ring_ptr #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // Clear has priority over increment; increment wraps from LAST to zero
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    end
  end

  // The pointer never leaves 0..DEPTH-1
  a_ptr_range: assert property (@(posedge clk) disable iff (rst)
    int'(ptr) < DEPTH);

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch/decode queue: buffers up to DEPTH fetch bundles between IF and ID
// so that fetch can run ahead of a stalled decoder.
// Optional feature: define FETCH_DECODE_QUEUE_BYPASS_EN to let a bundle
// arriving at an empty queue appear on the output in the same cycle.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      stall,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_mask,
  input  DECODE_REQUIRE [WIDTH-1:0] in_bundle,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_mask,
  output DECODE_REQUIRE [WIDTH-1:0] out_bundle,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam fdq_entry_t ENTRY_KEEP = fdq_keep_mask(WIDTH);

  fdq_entry_t       entries [DEPTH];
  fdq_entry_t       in_entry;
  fdq_entry_t       head_entry;
  fdq_entry_t       sel_entry;
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             in_fire;
  logic             out_fire;
  logic             write_en;
  logic             pop_en;
  logic             bypass_active;
  logic             bypass_taken;

  // Handshakes; in_ready looks only at registered state so there is no
  // combinational path from out_ready back to IF
  assign in_ready = (count != DEPTH_CNT) && !rst;
  assign in_fire  = in_valid && in_ready && !flush;

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
  assign bypass_active = (count == '0) && in_fire && (|in_mask);
  assign bypass_taken  = bypass_active && out_fire;
`else
  assign bypass_active = 1'b0;
  assign bypass_taken  = 1'b0;
`endif

  assign out_valid = ((count != '0) || bypass_active) && !rst;
  assign out_fire  = out_valid && out_ready && !stall && !flush;

  // A bundle with no live slots is accepted but never stored; a bypassed
  // bundle consumed in the same cycle never touches the ring
  assign write_en = in_fire && (|in_mask) && !bypass_taken;
  assign pop_en   = out_fire && !bypass_taken;

  // Widen the incoming bundle to the stored entry format
  always_comb begin
    in_entry                     = FDQ_ZERO_ENTRY;
    in_entry.mask[WIDTH-1:0]     = in_mask;
    in_entry.bundle[WIDTH-1:0]   = in_bundle;
  end

  assign head_entry = entries[head_ptr];
  assign sel_entry  = bypass_active ? in_entry : head_entry;

  // Head data is forced to zero whenever nothing valid is presented
  always_comb begin
    out_mask   = '0;
    out_bundle = '0;
    if (out_valid) begin
      out_mask   = sel_entry.mask[WIDTH-1:0];
      out_bundle = sel_entry.bundle[WIDTH-1:0];
    end
  end

  fdq_ring_ptr #(.DEPTH(DEPTH)) u_head_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop_en),
    .ptr (head_ptr)
  );

  fdq_ring_ptr #(.DEPTH(DEPTH)) u_tail_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (write_en),
    .ptr (tail_ptr)
  );

  // Ring storage: clear on reset/flush, clear the vacated head, write tail
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= FDQ_ZERO_ENTRY;
      end
    end else begin
      if (pop_en) begin
        entries[head_ptr] <= FDQ_ZERO_ENTRY;
      end
      if (write_en) begin
        entries[tail_ptr] <= in_entry;
      end
    end
  end

  // Occupancy tracks writes minus pops; simultaneous ones cancel
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      case ({write_en, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  a_count_max: assert property (@(posedge clk) disable iff (rst)
    int'(count) <= DEPTH);

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    pop_en |-> (count != '0));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (write_en && !pop_en) |-> (count != DEPTH_CNT));

  a_head_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_fire && !flush) |=> $stable(out_bundle));

  a_unused_slots_zero: assert property (@(posedge clk) disable iff (rst)
    (head_entry & ~ENTRY_KEEP) == FDQ_ZERO_ENTRY);

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed testbench for fetch_decode_queue (WIDTH=4, DEPTH=4).
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef DECODE_REQUIRE [WIDTH-1:0] bundle_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             stall;
  logic             in_valid;
  logic [WIDTH-1:0] in_mask;
  bundle_t          in_bundle;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_mask;
  bundle_t          out_bundle;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;

  fetch_decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .stall      (stall),
    .in_valid   (in_valid),
    .in_mask    (in_mask),
    .in_bundle  (in_bundle),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_mask   (out_mask),
    .out_bundle (out_bundle),
    .out_ready  (out_ready),
    .count      (count)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Slot i of a bundle starting at PC base
  function automatic bundle_t make_bundle(logic [31:0] base);
    bundle_t b;
    for (int i = 0; i < WIDTH; i++) begin
      b[i].pc    = base + 32'(4 * i);
      b[i].instr = 32'hA000_0000 | (base + 32'(i));
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] fill_mask(int k);
    case (k)
      0:       return 4'b1111;
      1:       return 4'b0111;
      2:       return 4'b0011;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] cycle_mask(int k);
    return WIDTH'((k % 15) + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    in_valid  = 1'b0;
    in_mask   = '0;
    in_bundle = '0;
    out_ready = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic set_input(logic [WIDTH-1:0] mask, logic [31:0] base);
    in_valid  = 1'b1;
    in_mask   = mask;
    in_bundle = make_bundle(base);
  endtask

  task automatic push(logic [WIDTH-1:0] mask, logic [31:0] base);
    set_input(mask, base);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    in_valid = 1'b1;
    in_mask  = 4'b1111;
    tick();
    tick();
    settle();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    rst = 1'b0;
    drive_idle();
    settle();
    checks++;
    if (out_valid !== 1'b0 || out_mask !== 4'b0000 || count !== 3'd0) begin
      errors++; $display("[TB] FAIL reset_state: valid %b mask %b count %0d want 0 0000 0", out_valid, out_mask, count);
    end
    checks++;
    if (out_bundle !== bundle_t'('0)) begin
      errors++; $display("[TB] FAIL reset_bundle: got %h want 0", out_bundle);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 4; k++) push(fill_mask(k), 32'h100 + 32'(16 * k));
    settle();
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL fill_full: count %0d ready %b want 4 0", count, in_ready);
    end
    push(4'b1111, 32'h140);
    settle();
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("[TB] FAIL fifth_push_refused: count %0d want 4", count);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_mask !== fill_mask(k) || out_bundle !== make_bundle(32'h100 + 32'(16 * k))) begin
        errors++; $display("[TB] FAIL drain%0d: valid %b mask %b pc0 %h want 1 %b %h", k, out_valid, out_mask, out_bundle[0].pc, fill_mask(k), 32'h100 + 32'(16 * k));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      settle();
    end
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_mask !== 4'b0000) begin
      errors++; $display("[TB] FAIL drain_empty: count %0d valid %b mask %b want 0 0 0000", count, out_valid, out_mask);
    end
  endtask

  task automatic test_full_pop_push();
    for (int k = 0; k < 4; k++) push(fill_mask(k), 32'h100 + 32'(16 * k));
    set_input(4'b1111, 32'h140);
    out_ready = 1'b1;
    settle();
    checks++;
    if (in_ready !== 1'b0 || out_bundle !== make_bundle(32'h100)) begin
      errors++; $display("[TB] FAIL full_pop_push_ready: ready %b pc0 %h want 0 100", in_ready, out_bundle[0].pc);
    end
    tick();
    out_ready = 1'b0;
    settle();
    checks++;
    if (count !== 3'd3 || in_ready !== 1'b1 || out_bundle !== make_bundle(32'h110)) begin
      errors++; $display("[TB] FAIL full_pop_count: count %0d ready %b pc0 %h want 3 1 110", count, in_ready, out_bundle[0].pc);
    end
    tick();
    in_valid = 1'b0;
    settle();
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("[TB] FAIL full_refill: count %0d want 4", count);
    end
    for (int k = 1; k < 5; k++) begin
      checks++;
      if (out_mask !== ((k == 4) ? 4'b1111 : fill_mask(k)) || out_bundle !== make_bundle(32'h100 + 32'(16 * k))) begin
        errors++; $display("[TB] FAIL full_order%0d: mask %b pc0 %h want pc0 %h", k, out_mask, out_bundle[0].pc, 32'h100 + 32'(16 * k));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      settle();
    end
  endtask

  task automatic test_back_to_back();
    push(cycle_mask(0), 32'h200);
    for (int i = 0; i < 20; i++) begin
      set_input(cycle_mask(i + 1), 32'h200 + 32'(16 * (i + 1)));
      out_ready = 1'b1;
      settle();
      checks++;
      if (count !== 3'd1 || out_mask !== cycle_mask(i) || out_bundle !== make_bundle(32'h200 + 32'(16 * i))) begin
        errors++; $display("[TB] FAIL b2b%0d: count %0d mask %b pc0 %h want 1 %b %h", i, count, out_mask, out_bundle[0].pc, cycle_mask(i), 32'h200 + 32'(16 * i));
      end
      tick();
    end
    in_valid = 1'b0;
    settle();
    checks++;
    if (count !== 3'd1 || out_mask !== cycle_mask(20) || out_bundle !== make_bundle(32'h340)) begin
      errors++; $display("[TB] FAIL b2b_last: count %0d mask %b pc0 %h want 1 %b 340", count, out_mask, out_bundle[0].pc, cycle_mask(20));
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) push(4'b1111, 32'h300 + 32'(16 * k));
    stall     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++;
      if (count !== 3'd3 || out_valid !== 1'b1 || out_bundle !== make_bundle(32'h300)) begin
        errors++; $display("[TB] FAIL stall_hold%0d: count %0d valid %b pc0 %h want 3 1 300", i, count, out_valid, out_bundle[0].pc);
      end
      tick();
    end
    stall = 1'b0;
    tick();
    settle();
    checks++;
    if (count !== 3'd2 || out_bundle !== make_bundle(32'h310)) begin
      errors++; $display("[TB] FAIL stall_release: count %0d pc0 %h want 2 310", count, out_bundle[0].pc);
    end
    tick();
    tick();
    out_ready = 1'b0;
    settle();
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("[TB] FAIL stall_drain: count %0d want 0", count);
    end
  endtask

  task automatic test_empty_mask();
    set_input(4'b0000, 32'h700);
    settle();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL empty_mask_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    settle();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL empty_mask_drop: count %0d valid %b want 0 0", count, out_valid);
    end
    push(4'b0101, 32'h710);
    push(4'b0000, 32'h720);
    push(4'b1010, 32'h730);
    settle();
    checks++;
    if (count !== 3'd2 || out_mask !== 4'b0101 || out_bundle !== make_bundle(32'h710)) begin
      errors++; $display("[TB] FAIL empty_mask_first: count %0d mask %b pc0 %h want 2 0101 710", count, out_mask, out_bundle[0].pc);
    end
    out_ready = 1'b1;
    tick();
    settle();
    checks++;
    if (out_mask !== 4'b1010 || out_bundle !== make_bundle(32'h730)) begin
      errors++; $display("[TB] FAIL empty_mask_second: mask %b pc0 %h want 1010 730", out_mask, out_bundle[0].pc);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    push(4'b1111, 32'h400);
    push(4'b1111, 32'h410);
    flush     = 1'b1;
    out_ready = 1'b1;
    set_input(4'b1111, 32'h500);
    tick();
    drive_idle();
    settle();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_mask !== 4'b0000 || out_bundle !== bundle_t'('0)) begin
      errors++; $display("[TB] FAIL flush_state: count %0d valid %b mask %b want 0 0 0000", count, out_valid, out_mask);
    end
    push(4'b0011, 32'h510);
    settle();
    checks++;
    if (count !== 3'd1 || out_bundle !== make_bundle(32'h510)) begin
      errors++; $display("[TB] FAIL flush_input_absent: count %0d pc0 %h want 1 510", count, out_bundle[0].pc);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    push(4'b1111, 32'h520);
    rst   = 1'b1;
    flush = 1'b1;
    set_input(4'b1111, 32'h530);
    settle();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_flush_ready: got %b want 0", in_ready);
    end
    tick();
    rst = 1'b0;
    drive_idle();
    settle();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_flush_state: count %0d valid %b ready %b want 0 0 1", count, out_valid, in_ready);
    end
  endtask

  task automatic test_bypass();
    set_input(4'b1111, 32'h600);
    out_ready = 1'b1;
    settle();
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
    checks++;
    if (out_valid !== 1'b1 || out_bundle !== make_bundle(32'h600)) begin
      errors++; $display("[TB] FAIL bypass_same_cycle: valid %b pc0 %h want 1 600", out_valid, out_bundle[0].pc);
    end
    tick();
    drive_idle();
    settle();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL bypass_no_write: count %0d valid %b want 0 0", count, out_valid);
    end
`else
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL latency_same_cycle: valid %b want 0", out_valid);
    end
    tick();
    in_valid = 1'b0;
    settle();
    checks++;
    if (out_valid !== 1'b1 || count !== 3'd1 || out_bundle !== make_bundle(32'h600)) begin
      errors++; $display("[TB] FAIL latency_next_cycle: valid %b count %0d pc0 %h want 1 1 600", out_valid, count, out_bundle[0].pc);
    end
    tick();
    drive_idle();
    settle();
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("[TB] FAIL latency_pop: count %0d want 0", count);
    end
`endif
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_fill_drain();
    test_full_pop_push();
    test_back_to_back();
    test_stall();
    test_empty_mask();
    test_flush();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
